div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is required to work.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low (rst==0 at a rising edge resets).
REQ-004 SHALL have port dividend_i  input  WIDTH  numerator from EX.
REQ-005 SHALL have port divisor_i  input  WIDTH  denominator from EX.
REQ-006 SHALL have port op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (codes in defines).
REQ-007 SHALL have port start_i  input  1  request pulse; operands/op/rd sampled when accepted.
REQ-008 SHALL have port rd_addr_i  input  5  destination register tag.
REQ-009 SHALL have port flush_i  input  1  abort (taken jump/flush from ctrl).
REQ-010 SHALL have port result_o  output  WIDTH  quotient or remainder.
REQ-011 SHALL have port ready_o  output  1  one-cycle completion strobe.
REQ-012 SHALL have port busy_o  output  1  unit occupied; ctrl uses it to hold if_id/id_ex.
REQ-013 SHALL have port rd_addr_o  output  5  tag of completing op.
REQ-014 SHALL have port reg_wen_o  output  1  write-enable, equal to ready_o.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE.
REQ-016 SHALL accept start_i only in IDLE with flush_i==0; start_i in CALC/DONE is ignored.
REQ-017 On accept, SHALL latch op, rd_addr, |dividend|, |divisor| (abs only for signed ops) and result signs; go to CALC, busy_o=1 from the next cycle.
REQ-018 CALC SHALL perform one restoring shift-subtract step per cycle, exactly WIDTH steps, using a WIDTH-bit counter-free shift or 6-bit counter.
REQ-019 After step WIDTH, SHALL enter DONE; in DONE ready_o=1, reg_wen_o=1, busy_o=0 for exactly one cycle, then IDLE.
REQ-020 Normal latency SHALL be WIDTH+2 cycles from accept edge to ready_o high (DIVU 100/7: ready 34 cycles after accept).
REQ-021 Signed quotient SHALL be negated iff operand signs differ; signed remainder SHALL take dividend's sign.
REQ-022 Divisor==0 SHALL skip CALC: DONE next cycle; quotient all-ones, remainder = dividend (unmodified).
REQ-023 DIV/REM with dividend 0x80000000, divisor 0xFFFFFFFF SHALL skip CALC: quotient 0x80000000, remainder 0.
REQ-024 result_o, rd_addr_o SHALL be valid only while ready_o=1; otherwise hold last value.
REQ-025 flush_i=1 in CALC or DONE SHALL return to IDLE next cycle with ready_o/reg_wen_o suppressed; flush wins over completion in same cycle.
REQ-026 start_i and flush_i together in IDLE SHALL not accept.
REQ-027 busy_o SHALL be 1 in CALC only (combinational from state).

Reset
REQ-028 rst==0 SHALL force IDLE, result_o=0, rd_addr_o=0, ready_o=0, reg_wen_o=0, busy_o=0, internal registers 0.
REQ-029 Reset mid-CALC SHALL abandon the op with no completion strobe.
REQ-030 Reset SHALL dominate start_i and flush_i.

Structure
REQ-031 Op codes (DIV/DIVU/REM/REMU) and FSM state encodings SHALL live in the shared defines file.
REQ-032 Output/result registers SHALL use the existing dff_set register cell where a plain registered value suffices.
REQ-033 No further sub-module; datapath (abs, shift-subtract, sign fixup) stays in div_unit.

Verification
REQ-034 DIVU 100/7 -> ready after 34 cycles, result 14; REMU same -> 2; rd_addr_o matches tag.
REQ-035 DIV -20/3 -> 0xFFFFFFFA (-6); REM -20/3 -> 0xFFFFFFFE (-2).
REQ-036 DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; both ready 2 cycles after accept.
REQ-037 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; ready 2 cycles after accept.
REQ-038 flush_i at cycle 10 of CALC -> no ready_o, busy_o 0 next cycle; new start then completes correctly.
REQ-039 rst low during CALC -> all outputs 0 next cycle, no strobe; start during busy ignored, first op result unaffected.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the divider: operation codes, FSM state encoding and
// small op-decoding helpers used by the datapath.
package div_unit_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_unit_dff_set.sv
// Plain register cell: loads set_data while rst is low, otherwise captures din
// when en is high and holds its value otherwise.
module div_unit_dff_set #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] set_data,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] qout
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            qout <= set_data;
        end else if (en) begin
            qout <= din;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (DIV/DIVU/REM/REMU). Operates on magnitudes,
// one shift-subtract step per cycle, then applies the sign fixup on completion.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic [1:0]       op_i,
    input  logic             start_i,
    input  logic [4:0]       rd_addr_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic [4:0]       rd_addr_o,
    output logic             reg_wen_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [1:0]       op_reg;
    logic [4:0]       rd_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dsr_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             ready_reg;

    logic             accept;
    logic             in_signed;
    logic             div_zero;
    logic             overflow;
    logic             special;
    logic             finishing;
    logic             result_wen;
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH-1:0] special_res;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] final_res;
    logic [WIDTH-1:0] result_next;
    logic [4:0]       rd_next;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;

    assign accept       = (state_reg == ST_IDLE) && start_i && !flush_i;
    assign in_signed    = op_is_signed(op_i);
    assign dividend_abs = (in_signed && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    assign divisor_abs  = (in_signed && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    assign div_zero = (divisor_i == '0);
    assign overflow = in_signed && (dividend_i == MIN_NEG) && (divisor_i == '1);
    assign special  = div_zero || overflow;

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = op_is_rem(op_i) ? dividend_i : '1;
        end else begin
            special_res = op_is_rem(op_i) ? '0 : MIN_NEG;
        end
    end

    // Remainder is always below the divisor, so WIDTH+1 bits hold the shifted
    // partial remainder and the borrow lands in the top bit.
    assign rem_shift = {rem_reg, quo_reg[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, dsr_reg};
    assign quo_step  = {quo_reg[WIDTH-2:0], ~rem_diff[WIDTH]};
    assign rem_step  = rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];

    assign final_res = op_is_rem(op_reg) ? (neg_r_reg ? -rem_step : rem_step)
                                         : (neg_q_reg ? -quo_step : quo_step);

    assign finishing   = (state_reg == ST_CALC) && !flush_i && (cnt_reg == CW'(WIDTH - 1));
    assign result_wen  = (accept && special) || finishing;
    assign result_next = accept ? special_res : final_res;
    assign rd_next     = accept ? rd_addr_i : rd_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
            rd_reg    <= '0;
            quo_reg   <= '0;
            rem_reg   <= '0;
            dsr_reg   <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    ready_reg <= 1'b0;
                    if (accept) begin
                        op_reg    <= op_i;
                        rd_reg    <= rd_addr_i;
                        quo_reg   <= dividend_abs;
                        dsr_reg   <= divisor_abs;
                        rem_reg   <= '0;
                        cnt_reg   <= '0;
                        neg_q_reg <= in_signed && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                        neg_r_reg <= in_signed && dividend_i[WIDTH-1];
                        if (special) begin
                            state_reg <= ST_DONE;
                            ready_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (flush_i) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        quo_reg <= quo_step;
                        rem_reg <= rem_step;
                        cnt_reg <= cnt_reg + 1'b1;
                        if (finishing) begin
                            state_reg <= ST_DONE;
                            ready_reg <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    div_unit_dff_set #(.DW(WIDTH)) u_result_reg (
        .clk      (clk),
        .rst      (rst),
        .en       (result_wen),
        .set_data ('0),
        .din      (result_next),
        .qout     (result_o)
    );

    div_unit_dff_set #(.DW(5)) u_rd_reg (
        .clk      (clk),
        .rst      (rst),
        .en       (result_wen),
        .set_data (5'd0),
        .din      (rd_next),
        .qout     (rd_addr_o)
    );

    // A flush arriving while the strobe is up still cancels the write-back.
    assign ready_o   = ready_reg && !flush_i;
    assign reg_wen_o = ready_reg && !flush_i;
    assign busy_o    = (state_reg == ST_CALC);

endmodule
